// File: rtl/edge_line_writeback.sv
`default_nettype none
// ============================================================================
// Module      : edge_line_writeback
// Description : Write-back stage of the edge-detection coprocessor. Processed
//               64-bit lines arrive as one-cycle strobes with their output
//               index, are buffered in a small FIFO and each is written to
//               the result RAM as two 32-bit words at base + 2*index (low
//               word first). done is raised once the armed number of lines
//               has been written.
// Ports       : clk_50M, reset (async, active high)
//               start, address_out_base, line_count        - arm a new image
//               line_valid, line_data, line_index          - incoming lines
//               wr_en, wr_address, wr_data                 - result RAM port
//               busy, done, overflow, lines_written        - status
// Revision    : 1.0 - initial release
// ============================================================================
module edge_line_writeback #(
   parameter int LINE_W     = 64,
   parameter int WORD_W     = 32,
   parameter int ADDR_W     = 12,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk_50M,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] address_out_base,
   input  logic [ADDR_W-1:0] line_count,
   input  logic              line_valid,
   input  logic [LINE_W-1:0] line_data,
   input  logic [ADDR_W-1:0] line_index,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_address,
   output logic [WORD_W-1:0] wr_data,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W-1:0] lines_written
);

   localparam int                C_PTR_W    = $clog2(FIFO_DEPTH);
   localparam int                C_ENTRY_W  = ADDR_W + LINE_W;
   localparam logic [C_PTR_W:0]  C_OCC_FULL = (C_PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [C_PTR_W-1:0] C_PTR_ONE = {{(C_PTR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ARMED    = 3'd1,
      S_WRITE_LO = 3'd2,
      S_WRITE_HI = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t               r_state;
   logic [ADDR_W-1:0]    r_base;
   logic [ADDR_W-1:0]    r_count;

   // Line buffer: each entry holds {index, data}
   logic [C_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
   logic [C_PTR_W-1:0]   r_wr_ptr;
   logic [C_PTR_W-1:0]   r_rd_ptr;
   logic [C_PTR_W:0]     r_occ;

   logic                 w_active;
   logic                 w_pop;
   logic                 w_push_req;
   logic                 w_push_ok;
   logic                 w_drop;
   logic [C_ENTRY_W-1:0] w_head;
   logic [LINE_W-1:0]    w_head_data;
   logic [ADDR_W-1:0]    w_head_idx;
   logic [ADDR_W-1:0]    w_addr_lo;
   logic [ADDR_W-1:0]    w_addr_hi;

   assign w_active   = (r_state == S_ARMED) || (r_state == S_WRITE_LO) ||
                       (r_state == S_WRITE_HI);
   // The head line is retired on the cycle its high word is presented.
   assign w_pop      = (r_state == S_WRITE_HI);
   assign w_push_req = line_valid && w_active;
   // A full buffer still accepts a line when the head leaves in the same cycle.
   assign w_push_ok  = w_push_req && ((r_occ != C_OCC_FULL) || w_pop);
   assign w_drop     = w_push_req && !w_push_ok;

   assign w_head      = r_mem[r_rd_ptr];
   assign w_head_data = w_head[LINE_W-1:0];
   assign w_head_idx  = w_head[C_ENTRY_W-1:LINE_W];
   // Modulo-2^ADDR_W arithmetic; wrap-around is intentional and silent.
   assign w_addr_lo   = r_base + w_head_idx + w_head_idx;
   assign w_addr_hi   = w_addr_lo + C_ADDR_ONE;

   // Storage needs no reset: occupancy/pointers define validity.
   always_ff @(posedge clk_50M) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= {line_index, line_data};
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         case ({w_push_ok, w_pop})
            2'b10:   r_occ <= r_occ + 1'b1;
            2'b01:   r_occ <= r_occ - 1'b1;
            default: r_occ <= r_occ;
         endcase
      end
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_base        <= '0;
         r_count       <= '0;
         wr_en         <= 1'b0;
         wr_address    <= '0;
         wr_data       <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         overflow      <= 1'b0;
         lines_written <= '0;
      end else begin
         if (w_drop) begin
            overflow <= 1'b1;
         end
         case (r_state)
            S_IDLE, S_DONE: begin
               wr_en <= 1'b0;
               if (start) begin
                  r_base        <= address_out_base;
                  r_count       <= line_count;
                  lines_written <= '0;
                  overflow      <= 1'b0;
                  busy          <= 1'b1;
                  done          <= 1'b0;
                  r_state       <= S_ARMED;
               end
            end
            S_ARMED: begin
               if (lines_written == r_count) begin
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_occ != '0) begin
                  wr_en      <= 1'b1;
                  wr_address <= w_addr_lo;
                  wr_data    <= w_head_data[WORD_W-1:0];
                  r_state    <= S_WRITE_LO;
               end
            end
            S_WRITE_LO: begin
               wr_en      <= 1'b1;
               wr_address <= w_addr_hi;
               wr_data    <= w_head_data[LINE_W-1:WORD_W];
               r_state    <= S_WRITE_HI;
            end
            S_WRITE_HI: begin
               wr_en         <= 1'b0;
               lines_written <= lines_written + C_ADDR_ONE;
               r_state       <= S_ARMED;
            end
            default: begin
               wr_en   <= 1'b0;
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_edge_line_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_line_writeback
// Description : Directed self-checking bench for edge_line_writeback. RAM
//               writes are captured into a queue on each rising edge and
//               compared against hand-computed address/data pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_line_writeback;

   logic        clk_50M;
   logic        reset;
   logic        start;
   logic [11:0] address_out_base;
   logic [11:0] line_count;
   logic        line_valid;
   logic [63:0] line_data;
   logic [11:0] line_index;
   logic        wr_en;
   logic [11:0] wr_address;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        overflow;
   logic [11:0] lines_written;

   int n_tests = 0;
   int n_fail  = 0;
   logic [43:0] wq[$];

   edge_line_writeback dut (
      .clk_50M          (clk_50M),
      .reset            (reset),
      .start            (start),
      .address_out_base (address_out_base),
      .line_count       (line_count),
      .line_valid       (line_valid),
      .line_data        (line_data),
      .line_index       (line_index),
      .wr_en            (wr_en),
      .wr_address       (wr_address),
      .wr_data          (wr_data),
      .busy             (busy),
      .done             (done),
      .overflow         (overflow),
      .lines_written    (lines_written)
   );

   initial clk_50M = 1'b0;
   always #10 clk_50M = ~clk_50M;

   // RAM model: a write lands on the rising edge where wr_en is high.
   always @(posedge clk_50M) begin
      if (wr_en) wq.push_back({wr_address, wr_data});
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_50M);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_wr(input string tag, input logic [11:0] a, input logic [31:0] d);
      logic [43:0] e;
      e = (wq.size() > 0) ? wq.pop_front() : 44'hx;
      chk(tag, {20'h0, e}, {20'h0, a, d});
   endtask

   task automatic send_line(input logic [11:0] idx, input logic [63:0] d);
      line_valid = 1'b1;
      line_index = idx;
      line_data  = d;
      tick(1);
      line_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; address_out_base = '0; line_count = '0;
      line_valid = 1'b0; line_data = '0; line_index = '0;
      tick(3);
      chk("rst_wr_en", {63'h0, wr_en}, 64'h0);
      chk("rst_status", {60'h0, busy, done, overflow, 1'b0}, 64'h0);
      chk("rst_addr_data", {20'h0, wr_address, wr_data}, 64'h0);
      chk("rst_lines", {52'h0, lines_written}, 64'h0);
      reset = 1'b0;
      tick(2);

      // Basic two-line image; a start during busy must be ignored.
      wq.delete();
      address_out_base = 12'h100; line_count = 12'd2; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t1_armed", {62'h0, busy, done}, 64'h2);
      send_line(12'd0, 64'h1111_2222_3333_4444);
      tick(1);
      chk("t1_lat_lo", {31'h0, wr_en, 20'h0, wr_address}, {31'h0, 1'b1, 20'h0, 12'h100});
      tick(1);
      chk("t1_lat_hi", {31'h0, wr_en, 20'h0, wr_address}, {31'h0, 1'b1, 20'h0, 12'h101});
      tick(1);
      start = 1'b1; address_out_base = 12'h200; line_count = 12'd0;
      send_line(12'd1, 64'hAAAA_BBBB_CCCC_DDDD);
      start = 1'b0;
      tick(4);
      chk("t1_done", {62'h0, busy, done}, 64'h1);
      chk("t1_lines", {52'h0, lines_written}, 64'd2);
      chk("t1_nwr", wq.size(), 64'd4);
      chk_wr("t1_w0", 12'h100, 32'h3333_4444);
      chk_wr("t1_w1", 12'h101, 32'h1111_2222);
      chk_wr("t1_w2", 12'h102, 32'hCCCC_DDDD);
      chk_wr("t1_w3", 12'h103, 32'hAAAA_BBBB);

      // Address wrap-around.
      wq.delete();
      address_out_base = 12'hFFE; line_count = 12'd1; start = 1'b1;
      tick(1);
      start = 1'b0;
      send_line(12'd1, 64'h5555_6666_7777_8888);
      tick(5);
      chk("t2_done", {63'h0, done}, 64'h1);
      chk("t2_nwr", wq.size(), 64'd2);
      chk_wr("t2_w0", 12'h000, 32'h7777_8888);
      chk_wr("t2_w1", 12'h001, 32'h5555_6666);

      // Zero-line image; lines in DONE are ignored.
      wq.delete();
      address_out_base = 12'h050; line_count = 12'd0; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t3_s1", {62'h0, busy, done}, 64'h2);
      tick(1);
      chk("t3_s2", {62'h0, busy, done}, 64'h1);
      send_line(12'd3, 64'h1234);
      send_line(12'd4, 64'h5678);
      tick(2);
      chk("t3_nwr", wq.size(), 64'd0);
      chk("t3_ovf", {63'h0, overflow}, 64'h0);
      chk("t3_lines", {52'h0, lines_written}, 64'h0);

      // Burst of six back-to-back lines: the sixth is dropped.
      wq.delete();
      address_out_base = 12'h000; line_count = 12'd6; start = 1'b1;
      tick(1);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         send_line(12'(i), {32'hA000_0000 + 32'(i), 32'h0000_0B00 + 32'(i)});
      end
      tick(20);
      chk("t4_ovf", {63'h0, overflow}, 64'h1);
      chk("t4_status", {62'h0, busy, done}, 64'h2);
      chk("t4_lines", {52'h0, lines_written}, 64'd5);
      chk("t4_nwr", wq.size(), 64'd10);
      for (int i = 0; i < 5; i++) begin
         chk_wr("t4_lo", 12'(2 * i), 32'h0000_0B00 + 32'(i));
         chk_wr("t4_hi", 12'(2 * i + 1), 32'hA000_0000 + 32'(i));
      end

      // Asynchronous reset in the middle of a low-word write.
      send_line(12'd2, 64'hFFFF_0000_FFFF_0000);
      tick(1);
      chk("t5_lo_active", {63'h0, wr_en}, 64'h1);
      wq.delete();
      #2 reset = 1'b1;
      #1;
      chk("t5_async_wr_en", {63'h0, wr_en}, 64'h0);
      chk("t5_async_status", {61'h0, busy, done, overflow}, 64'h0);
      chk("t5_async_lines", {52'h0, lines_written}, 64'h0);
      #2 reset = 1'b0;
      address_out_base = 12'h300; line_count = 12'd1; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(5);
      chk("t5_fifo_empty", wq.size(), 64'd0);
      chk("t5_waiting", {62'h0, busy, done}, 64'h2);
      send_line(12'd0, 64'hDEAD_BEEF_0123_4567);
      tick(5);
      chk("t5_done", {63'h0, done}, 64'h1);
      chk_wr("t5_w0", 12'h300, 32'h0123_4567);
      chk_wr("t5_w1", 12'h301, 32'hDEAD_BEEF);

      // Re-arm after done.
      address_out_base = 12'h400; line_count = 12'd1; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("t6_rearm", {62'h0, busy, done}, 64'h2);
      chk("t6_lines", {52'h0, lines_written}, 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/edge_line_writeback.md
Name: edge_line_writeback

Overview:
- Downstream stage of the edge-detection coprocessor.
- Accepts each processed 64-bit pixel line, strobed by the coprocessor's one-cycle line pulse together with the line's output index.
- Buffers lines in a small FIFO and serializes each into two 32-bit writes to the result RAM at address_out_base + 2*index.
- Signals completion once the programmed number of lines has been written.

Parameters:
- LINE_W, 64, width of one processed line.
- WORD_W, 32, result RAM data width; LINE_W = 2*WORD_W.
- ADDR_W, 12, RAM address and line-index width.
- FIFO_DEPTH, 4, line buffer entries (power of two).

Ports:
- clk_50M  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new image write-back.
- address_out_base  in  ADDR_W  base address of the result image; sampled at start.
- line_count  in  ADDR_W  number of lines expected; sampled at start.
- line_valid  in  1  one-cycle strobe; line_data/line_index valid.
- line_data  in  LINE_W  processed line.
- line_index  in  ADDR_W  line number within the image.
- wr_en  out  1  RAM write enable.
- wr_address  out  ADDR_W  RAM write address.
- wr_data  out  WORD_W  RAM write data.
- busy  out  1  armed and not yet done.
- done  out  1  all lines written; held until next start.
- overflow  out  1  sticky: a line was dropped because the FIFO was full.
- lines_written  out  ADDR_W  count of lines fully written.

Behaviour:
- Reset (async, any time, including mid-write): state=IDLE; FIFO emptied; wr_en=0, wr_address=0, wr_data=0, busy=0, done=0, overflow=0, lines_written=0. No partial write completes after reset.
- All outputs are registered.
- States:
  - IDLE: start -> latch base and count; clear lines_written and overflow; go ARMED.
  - ARMED: if lines_written==count_l -> DONE; else if FIFO non-empty -> WRITE_LO.
  - WRITE_LO: wr_en=1, wr_address=base_l+2*idx, wr_data=data[31:0]; go WRITE_HI.
  - WRITE_HI: wr_en=1, wr_address=base_l+2*idx+1, wr_data=data[63:32]; pop FIFO; lines_written+1; go ARMED.
  - DONE: done=1, busy=0; start -> behave as in IDLE (re-arm, done drops next cycle).
- busy=1 in ARMED, WRITE_LO and WRITE_HI; wr_en=0 in every other state.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent, with no flag.
- Latency: with the FIFO empty and state ARMED, a line_valid at edge N gives a low-word write at edge N+2 and a high-word write at N+3. Sustained throughput is one line per 3 cycles.
- FIFO push: occurs only when line_valid=1 and state ∈ {ARMED, WRITE_LO, WRITE_HI}.
  - Push is accepted if occupancy < FIFO_DEPTH, or if a pop occurs in the same cycle (full plus simultaneous pop is accepted).
  - Otherwise the line is dropped and overflow is set; overflow stays set until the next start.
- line_valid in IDLE or DONE is ignored: no push, no overflow.
- start while busy=1 is ignored.
- line_count==0: start -> ARMED -> DONE; done=1 two cycles after start, with no writes.
- Lines are written in arrival order regardless of index value. Duplicate indices are written twice, and both are counted.

Test Plan:
- Reset, then start with base=0x100 and count=2; lines {idx0, 0x1111_2222_3333_4444} and {idx1, 0xAAAA_BBBB_CCCC_DDDD} sent 4 cycles apart -> writes (0x100, 0x33334444), (0x101, 0x11112222), (0x102, 0xCCCCDDDD), (0x103, 0xAAAABBBB); done=1 and lines_written=2.
- Burst: start with count=6, then 6 line_valid strobes on consecutive cycles -> first 5 accepted (4 buffered plus 1 pop overlap per timing), overflow=1, done never asserts; lines_written=5 after drain.
- Wrap-around: base=0xFFE, idx=1 -> writes to 0x000 and 0x001.
- count=0 -> done=1 two cycles after start, wr_en never high; line_valid while in DONE -> no writes, overflow stays 0.
- Reset asserted during WRITE_LO -> wr_en=0 immediately (async), FIFO empty; next start runs a clean sequence.
- start pulse while busy -> ignored, base and count unchanged; after done, a second start with new base re-arms, done=0 the next cycle, and lines_written=0.
